// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller states
// and the step-counter sizing helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must reach WIDTH-1, which always fits in $clog2(WIDTH) bits for WIDTH >= 2
  function automatic int step_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake and operand/result bus of the shift-add multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 32
);

  logic                 iStart;
  logic                 iSigned;
  logic [WIDTH-1:0]     iData_A;
  logic [WIDTH-1:0]     iData_B;
  logic                 oBusy;
  logic                 oDone;
  logic [2*WIDTH-1:0]   oProd;

  modport master (
    output iStart, iSigned, iData_A, iData_B,
    input  oBusy, oDone, oProd
  );

  modport slave (
    input  iStart, iSigned, iData_A, iData_B,
    output oBusy, oDone, oProd
  );

endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath: magnitude capture, shifting multiplicand/multiplier,
// accumulator and final sign correction of the product.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load_s,
  input  logic               run_s,
  input  logic               signed_s,
  input  logic [WIDTH-1:0]   a_s,
  input  logic [WIDTH-1:0]   b_s,
  output logic               b_rest_zero_s,
  output logic [2*WIDTH-1:0] prod_next_s
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    a_r;
  logic [PW-1:0]    acc_r;
  logic [WIDTH-1:0] b_r;
  logic             neg_r;
  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    acc_next_s;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without overflow
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      return WIDTH'(0) - x;
    end else begin
      return x;
    end
  endfunction

  // Partial-product add and sign-corrected result for the exit edge
  always_comb begin
    addend_s = '0;
    if (b_r[0]) begin
      addend_s = a_r;
    end else begin
      addend_s = '0;
    end
    acc_next_s    = acc_r + addend_s;
    b_rest_zero_s = (b_r[WIDTH-1:1] == '0);
    if (neg_r) begin
      prod_next_s = PW'(0) - acc_next_s;
    end else begin
      prod_next_s = acc_next_s;
    end
  end

  // Operand/accumulator registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_r   <= '0;
      b_r   <= '0;
      acc_r <= '0;
      neg_r <= 1'b0;
    end else if (load_s) begin
      a_r   <= {{WIDTH{1'b0}}, magnitude(a_s, signed_s)};
      b_r   <= magnitude(b_s, signed_s);
      acc_r <= '0;
      neg_r <= signed_s & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
    end else if (run_s) begin
      a_r   <= a_r << 1;
      b_r   <= b_r >> 1;
      acc_r <= acc_next_s;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier: controller FSM, step counter and registered
// handshake/result outputs around mult_datapath.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  seq_shift_add_multiplier_if.slave   bus
);

  localparam int SW = step_width(WIDTH);

  state_e             state_r;
  state_e             state_next_s;
  logic [SW-1:0]      step_r;
  logic               load_s;
  logic               run_s;
  logic               last_step_s;
  logic               exit_s;
  logic               b_rest_zero_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] prod_r;

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.iStart) state_next_s = ST_RUN;
        else            state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (exit_s) state_next_s = ST_DONE;
        else        state_next_s = ST_RUN;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath control strobes
  always_comb begin
    load_s = 1'b0;
    run_s  = 1'b0;
    case (state_r)
      ST_IDLE: load_s = bus.iStart;
      ST_RUN:  run_s  = 1'b1;
      ST_DONE: run_s  = 1'b0;
      default: run_s  = 1'b0;
    endcase
    last_step_s = (step_r == SW'(WIDTH - 1));
    exit_s      = run_s && (last_step_s || (EARLY_EXIT && b_rest_zero_s));
  end

  // Step counter
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      step_r <= '0;
    end else if (load_s) begin
      step_r <= '0;
    end else if (run_s) begin
      step_r <= step_r + SW'(1);
    end
  end

  // Registered handshake and result
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      prod_r <= '0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= exit_s;
      if (exit_s) prod_r <= prod_next_s;
    end
  end

  assign bus.oBusy = busy_r;
  assign bus.oDone = done_r;
  assign bus.oProd = prod_r;

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .Clock         (Clock),
    .Reset         (Reset),
    .load_s        (load_s),
    .run_s         (run_s),
    .signed_s      (bus.iSigned),
    .a_s           (bus.iData_A),
    .b_s           (bus.iData_B),
    .b_rest_zero_s (b_rest_zero_s),
    .prod_next_s   (prod_next_s)
  );

endmodule
